// File: rtl/counter_button_ctrl.sv
// counter_button_ctrl
//   Front end for the up/down counter datapath. Synchronises and debounces
//   two raw push buttons, arbitrates between them and issues single-cycle
//   increment/decrease pulses with hold-to-auto-repeat.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   en         : synchronous enable; no pulses while low
//   btn_inc    : raw increment button (async, active-high)
//   btn_dec    : raw decrease button (async, active-high)
//   increment  : registered one-cycle count-up pulse
//   decrease   : registered one-cycle count-down pulse
//   repeating  : registered, high while auto-repeating
module counter_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic increment,
  output logic decrease,
  output logic repeating
);

  localparam int DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_WAIT_RELEASE
  } state_t;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

  // Bit 0 = increment button, bit 1 = decrease button.
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     deb;
  logic [DCW-1:0] cnt [2];

  state_t        state, state_nx;
  dir_t          dir, dir_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic          pulse;
  logic          act_deb;
  logic          other_deb;
  logic          inc_nx, dec_nx, rep_nx;

  assign raw = {btn_dec, btn_inc};

  // Two-flop synchronisers followed by a consecutive-sample debouncer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DCW'(1);
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    dir_nx    = dir;
    tmr_nx    = tmr;
    pulse     = 1'b0;
    act_deb   = (dir == DIR_INC) ? deb[0] : deb[1];
    other_deb = (dir == DIR_INC) ? deb[1] : deb[0];

    case (state)
      S_IDLE: begin
        if (en) begin
          if (deb[0] && deb[1]) begin
            state_nx = S_WAIT_RELEASE;
          end else if (deb[0]) begin
            pulse    = 1'b1;
            dir_nx   = DIR_INC;
            tmr_nx   = '0;
            state_nx = S_DELAY;
          end else if (deb[1]) begin
            pulse    = 1'b1;
            dir_nx   = DIR_DEC;
            tmr_nx   = '0;
            state_nx = S_DELAY;
          end
        end
      end
      // DELAY and REPEAT share exits; only the timer terminal count differs.
      S_DELAY, S_REPEAT: begin
        if (!act_deb) begin
          state_nx = S_IDLE;
          tmr_nx   = '0;
        end else if (other_deb || !en) begin
          state_nx = S_WAIT_RELEASE;
          tmr_nx   = '0;
        end else if (tmr == ((state == S_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          pulse    = 1'b1;
          tmr_nx   = '0;
          state_nx = S_REPEAT;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_WAIT_RELEASE: begin
        if (!deb[0] && !deb[1]) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    inc_nx = pulse && (dir_nx == DIR_INC);
    dec_nx = pulse && (dir_nx == DIR_DEC);
    rep_nx = (state_nx == S_REPEAT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      dir       <= DIR_INC;
      tmr       <= '0;
      increment <= 1'b0;
      decrease  <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nx;
      dir       <= dir_nx;
      tmr       <= tmr_nx;
      increment <= inc_nx;
      decrease  <= dec_nx;
      repeating <= rep_nx;
    end
  end

endmodule

// File: tb/tb_counter_button_ctrl.sv
// tb_counter_button_ctrl
//   Self-checking bench for counter_button_ctrl: behavioural reference model
//   checked every cycle, directed scenarios with literal edge expectations,
//   then randomized button/enable/reset activity.
module tb_counter_button_ctrl;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RP = 4;

  localparam int M_IDLE  = 0;
  localparam int M_HELD  = 1;
  localparam int M_BLOCK = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic increment, decrease, repeating;

  counter_button_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .increment(increment),
    .decrease (decrease),
    .repeating(repeating)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int inc_edges[$];
  int dec_edges[$];
  int rep_first = -1;

  // Reference model state.
  logic dly  [2][2];
  logic hist [2][D];
  int   nv   [2];
  logic mdeb [2];
  int   mode;
  int   mdir;  // 0 = increment, 1 = decrease
  int   age;   // cycles since the first pulse of the current hold
  logic ei, ed, er;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      dly[b][0] = 1'b0;
      dly[b][1] = 1'b0;
      for (int k = 0; k < D; k++) hist[b][k] = 1'b0;
      nv[b]   = 0;
      mdeb[b] = 1'b0;
    end
    mode = M_IDLE;
    mdir = 0;
    age  = 0;
    ei   = 1'b0;
    ed   = 1'b0;
    er   = 1'b0;
  endtask

  task automatic model_step();
    logic raw [2];
    logic s;
    logic all_diff;
    logic held, other;
    logic fire;
    raw[0] = btn_inc;
    raw[1] = btn_dec;
    ei = 1'b0;
    ed = 1'b0;
    fire = 1'b0;

    // Arbitration uses the debounced levels as they stood before this edge.
    if (mode == M_IDLE) begin
      if (en) begin
        if (mdeb[0] && mdeb[1]) begin
          mode = M_BLOCK;
        end else if (mdeb[0] || mdeb[1]) begin
          mode = M_HELD;
          mdir = mdeb[0] ? 0 : 1;
          age  = 0;
          fire = 1'b1;
        end
      end
    end else if (mode == M_HELD) begin
      held  = mdeb[mdir];
      other = mdeb[1-mdir];
      if (!held) begin
        mode = M_IDLE;
      end else if (other || !en) begin
        mode = M_BLOCK;
      end else begin
        age++;
        if (age == RD || (age > RD && (age - RD) % RP == 0)) fire = 1'b1;
      end
    end else begin
      if (!mdeb[0] && !mdeb[1]) mode = M_IDLE;
    end
    if (fire) begin
      if (mdir == 0) ei = 1'b1;
      else ed = 1'b1;
    end
    er = (mode == M_HELD) && (age >= RD);

    // Debounced level flips once the last D synchronised samples all disagree.
    for (int b = 0; b < 2; b++) begin
      s = dly[b][0];
      dly[b][0] = dly[b][1];
      dly[b][1] = raw[b];
      for (int k = D - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = s;
      if (nv[b] < D) nv[b]++;
      if (nv[b] == D) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (hist[b][k] == mdeb[b]) all_diff = 1'b0;
        if (all_diff) mdeb[b] = s;
      end
    end
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    cyc++;
    if (reset) model_step();
    else begin
      ei = 1'b0;
      ed = 1'b0;
      er = 1'b0;
    end
    #1;
    check("increment", increment, ei);
    check("decrease", decrease, ed);
    check("repeating", repeating, er);
    if (increment === 1'b1) inc_edges.push_back(cyc);
    if (decrease === 1'b1) dec_edges.push_back(cyc);
    if (repeating === 1'b1 && rep_first < 0) rep_first = cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    inc_edges.delete();
    dec_edges.delete();
    rep_first = -1;
  endtask

  int n0;
  int p0;
  int r1;
  int len;

  initial begin
    model_reset();
    tick(3);
    check("reset increment", increment, 1'b0);
    check("reset decrease", decrease, 1'b0);
    check("reset repeating", repeating, 1'b0);
    reset = 1'b1;
    tick(5);

    // Single press: one pulse at N+6.
    clear_log();
    n0 = cyc + 1;
    btn_inc = 1'b1;
    tick(10);
    btn_inc = 1'b0;
    tick(15);
    check_int("single inc count", inc_edges.size(), 1);
    if (inc_edges.size() > 0) check_int("single inc edge", inc_edges[0], n0 + 6);
    check_int("single dec count", dec_edges.size(), 0);

    // Bounce then settle, then a lone 3-cycle glitch.
    clear_log();
    btn_dec = 1'b1; tick(1);
    btn_dec = 1'b0; tick(1);
    btn_dec = 1'b1; tick(1);
    btn_dec = 1'b0; tick(1);
    n0 = cyc + 1;
    btn_dec = 1'b1;
    tick(8);
    btn_dec = 1'b0;
    tick(15);
    check_int("bounce dec count", dec_edges.size(), 1);
    if (dec_edges.size() > 0) check_int("bounce dec edge", dec_edges[0], n0 + 6);
    clear_log();
    btn_dec = 1'b1;
    tick(3);
    btn_dec = 1'b0;
    tick(12);
    check_int("glitch dec count", dec_edges.size(), 0);

    // Auto-repeat: pulses at P, P+16, then every 4 through P+36.
    clear_log();
    n0 = cyc + 1;
    p0 = n0 + 6;
    btn_inc = 1'b1;
    tick(40);
    btn_inc = 1'b0;
    tick(20);
    check_int("repeat count", inc_edges.size(), 7);
    if (inc_edges.size() == 7) begin
      check_int("repeat first", inc_edges[0], p0);
      check_int("repeat second", inc_edges[1], p0 + 16);
      check_int("repeat third", inc_edges[2], p0 + 20);
      check_int("repeat last", inc_edges[6], p0 + 36);
    end
    check_int("repeating rise", rep_first, p0 + 16);

    // Conflict during DELAY, then simultaneous press from IDLE.
    clear_log();
    n0 = cyc + 1;
    btn_inc = 1'b1;
    tick(8);
    btn_dec = 1'b1;
    tick(20);
    btn_inc = 1'b0;
    tick(15);
    btn_dec = 1'b0;
    tick(15);
    check_int("conflict inc count", inc_edges.size(), 1);
    if (inc_edges.size() > 0) check_int("conflict inc edge", inc_edges[0], n0 + 6);
    check_int("conflict dec count", dec_edges.size(), 0);
    clear_log();
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    tick(12);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(15);
    check_int("both inc count", inc_edges.size(), 0);
    check_int("both dec count", dec_edges.size(), 0);

    // Enable dropped during a hold: no pulse until a fresh press.
    clear_log();
    btn_inc = 1'b1;
    tick(10);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(20);
    btn_inc = 1'b0;
    tick(15);
    check_int("enable hold count", inc_edges.size(), 1);
    n0 = cyc + 1;
    btn_inc = 1'b1;
    tick(10);
    btn_inc = 1'b0;
    tick(15);
    check_int("enable repress count", inc_edges.size(), 2);
    if (inc_edges.size() == 2) check_int("enable repress edge", inc_edges[1], n0 + 6);

    // Reset on a REPEAT pulse cycle, button still held afterwards.
    clear_log();
    n0 = cyc + 1;
    p0 = n0 + 6;
    btn_inc = 1'b1;
    tick(22);
    @(posedge clk);
    #2;
    check_int("pre-reset edge", cyc, p0 + 16);
    check("pre-reset pulse", increment, 1'b1);
    reset = 1'b0;
    #1;
    check("async reset increment", increment, 1'b0);
    check("async reset repeating", repeating, 1'b0);
    tick(2);
    clear_log();
    r1 = cyc + 1;
    reset = 1'b1;
    tick(12);
    check_int("post-reset count", inc_edges.size(), 1);
    if (inc_edges.size() > 0) check_int("post-reset edge", inc_edges[0], r1 + 6);
    btn_inc = 1'b0;
    tick(15);

    // Randomized segments of button, enable and occasional reset activity.
    for (int unsigned seg = 0; seg < 160; seg++) begin
      btn_inc = 1'($urandom_range(0, 1));
      btn_dec = ($urandom_range(0, 3) == 0);
      en      = ($urandom_range(0, 9) != 0);
      len     = $urandom_range(1, 45);
      for (int unsigned j = 0; j < 32'(len); j++) begin
        @(negedge clk);
        if ($urandom_range(0, 29) == 0) btn_inc = ~btn_inc;
        if ($urandom_range(0, 29) == 0) btn_dec = ~btn_dec;
      end
      if ($urandom_range(0, 24) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check("rand reset increment", increment, 1'b0);
        check("rand reset decrease", decrease, 1'b0);
        tick(2);
        reset = 1'b1;
      end
    end

    btn_inc = 1'b0;
    btn_dec = 1'b0;
    en = 1'b1;
    tick(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
